// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_BITS LSB-first, optional even parity, stop.
// Each bit is resolved by a 3-sample majority vote around mid-bit.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100000000,
    parameter int OVS_FACTOR = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rx,
    input  logic                 parity_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVS_FACTOR);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVS_FACTOR);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OVS_LAST = OW'(OVS_FACTOR - 1);
    localparam logic [OW-1:0] SMP_A    = OW'(OVS_FACTOR / 2 - 1);
    localparam logic [OW-1:0] SMP_B    = OW'(OVS_FACTOR / 2);
    localparam logic [OW-1:0] SMP_C    = OW'(OVS_FACTOR / 2 + 1);
    localparam logic [BW-1:0] NBITS    = BW'(DATA_BITS);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx: CLK_FREQ/(BAUD_RATE*OVS_FACTOR) must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_next;

    logic                 rx_m, rx_s;
    logic [DW-1:0]        div_cnt;
    logic [OW-1:0]        ovs_cnt;
    logic                 armed;
    logic                 pe_lat;
    logic                 smp0, smp1;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 perr_q;

    logic tick, start_det, decide, bit_end, maj;

    assign tick      = (div_cnt == DIV_LAST);
    assign start_det = (state == IDLE) && armed && !rx_s;
    assign decide    = tick && (ovs_cnt == SMP_C);
    assign bit_end   = tick && (ovs_cnt == OVS_LAST);
    assign maj       = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign rx_busy   = (state != IDLE);

    // Line idles high, so the synchronizer comes out of reset at 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (start_det) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_det) begin
                    state_next = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_cnt == NBITS) begin
                    state_next = pe_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is seen.
                if (decide) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed      <= 1'b0;
            pe_lat     <= 1'b0;
            smp0       <= 1'b0;
            smp1       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            perr_q     <= 1'b0;
            rx_data    <= '0;
            data_ready <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            // A low line must go high again before a new start is accepted.
            if (state != IDLE && state_next == IDLE) begin
                armed <= 1'b0;
            end else if (rx_s) begin
                armed <= 1'b1;
            end
            if (start_det) begin
                pe_lat  <= parity_enable;
                bit_cnt <= '0;
            end
            if (tick && ovs_cnt == SMP_A) begin
                smp0 <= rx_s;
            end
            if (tick && ovs_cnt == SMP_B) begin
                smp1 <= rx_s;
            end
            if (decide && state == DATA) begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (decide && state == PARITY) begin
                perr_q <= (^shreg) ^ maj;
            end
            if (decide && state == STOP) begin
                data_ready <= 1'b1;
                rx_data    <= shreg;
                parity_err <= pe_lat & perr_q;
                frame_err  <= ~maj;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx with a frame-level model and a per-cycle
// output monitor; runs at a fast baud so many frames fit in a short run.
module tb_uart_rx;

    localparam int DB   = 8;
    localparam int BAUD = 1000000;
    localparam int CLKF = 100000000;
    localparam int OVS  = 16;
    localparam int DIV  = CLKF / (BAUD * OVS);
    localparam int BIT  = DIV * OVS;
    localparam int MID  = 1 + (OVS / 2 + 1) * DIV;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rx = 1'b1;
    logic          parity_enable = 1'b0;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          parity_err;
    logic          frame_err;
    logic          rx_busy;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_BITS (DB),
        .BAUD_RATE (BAUD),
        .CLK_FREQ  (CLKF),
        .OVS_FACTOR(OVS)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx           (rx),
        .parity_enable(parity_enable),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    typedef struct {
        logic [DB-1:0] d;
        logic          pe;
        logic          fe;
        int            due;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input logic pen);
        return (1 + DB + int'(pen)) * OVS * DIV + (OVS / 2 + 2) * DIV + 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   diff;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                q.delete();
                last.d  = '0;
                last.pe = 1'b0;
                last.fe = 1'b0;
                check("rst_rx_data", 32'(rx_data), 0);
                check("rst_data_ready", 32'(data_ready), 0);
                check("rst_parity_err", 32'(parity_err), 0);
                check("rst_frame_err", 32'(frame_err), 0);
                check("rst_rx_busy", 32'(rx_busy), 0);
            end else if (data_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_ready: got data_ready=1 required 0 (cyc %0d)",
                             cyc);
                end else begin
                    e = q.pop_front();
                    check("ready_data", 32'(rx_data), 32'(e.d));
                    check("ready_parity_err", 32'(parity_err), 32'(e.pe));
                    check("ready_frame_err", 32'(frame_err), 32'(e.fe));
                    diff = cyc - e.due;
                    vectors++;
                    if (diff < -1 || diff > 1) begin
                        miscompares++;
                        $display("FAIL ready_time: got cyc %0d required %0d",
                                 cyc, e.due);
                    end
                    last = e;
                end
                check("busy_at_ready", 32'(rx_busy), 0);
            end else begin
                check("hold_rx_data", 32'(rx_data), 32'(last.d));
                check("hold_parity_err", 32'(parity_err), 32'(last.pe));
                check("hold_frame_err", 32'(frame_err), 32'(last.fe));
                if (q.size() > 0) begin
                    vectors++;
                    if (cyc > q[0].due + 1) begin
                        miscompares++;
                        $display("FAIL missing_ready: got none by cyc %0d required at %0d",
                                 cyc, q[0].due);
                        void'(q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic drive_frame(input logic [DB-1:0] d, input logic pen,
                               input logic pbit, input logic stop,
                               input logic toggle, input int corrupt,
                               input int gap);
        exp_t e;
        parity_enable = pen;
        rx = 1'b0;
        e.d   = d;
        e.pe  = pen ? ((^d) ^ pbit) : 1'b0;
        e.fe  = ~stop;
        e.due = cyc + lat(pen);
        q.push_back(e);
        wait_clks(BIT / 2);
        check("busy_start", 32'(rx_busy), 1);
        if (toggle) parity_enable = ~pen;
        wait_clks(BIT - BIT / 2);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            if (i == corrupt) begin
                wait_clks(MID - 3);
                rx = ~d[i];
                wait_clks(6);
                rx = d[i];
                wait_clks(BIT - MID - 3);
            end else begin
                wait_clks(BIT);
            end
        end
        if (pen) begin
            rx = pbit;
            wait_clks(BIT);
        end
        rx = stop;
        wait_clks(BIT);
        if (gap > 0) begin
            rx = 1'b1;
            wait_clks(gap);
        end
    endtask

    initial begin
        logic [DB-1:0] d;
        logic          pen, pbit, stop;
        int            cor, gap;

        last.d  = '0;
        last.pe = 1'b0;
        last.fe = 1'b0;
        last.due = 0;
        fork
            monitor();
        join_none

        wait_clks(5);
        check("init_rx_data", 32'(rx_data), 0);
        check("init_rx_busy", 32'(rx_busy), 0);
        resetn = 1'b1;
        wait_clks(10);

        // plain frame
        drive_frame(8'hD5, 1'b0, 1'b0, 1'b1, 1'b0, -1, 20);
        check("t1_data", 32'(rx_data), 32'hD5);
        check("t1_perr", 32'(parity_err), 0);
        check("t1_ferr", 32'(frame_err), 0);
        check("t1_busy", 32'(rx_busy), 0);

        // even parity, good then bad, then mid-frame toggles
        drive_frame(8'hD5, 1'b1, 1'b1, 1'b1, 1'b0, -1, 20);
        check("t2_good_perr", 32'(parity_err), 0);
        drive_frame(8'hD5, 1'b1, 1'b0, 1'b1, 1'b0, -1, 20);
        check("t2_bad_perr", 32'(parity_err), 1);
        check("t2_bad_data", 32'(rx_data), 32'hD5);
        drive_frame(8'hD5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 20);
        check("t2_tog_perr", 32'(parity_err), 1);
        drive_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, -1, 20);
        check("t2_tog_off", 32'(parity_err), 0);
        check("t2_tog_data", 32'(rx_data), 32'h5A);

        // framing error followed by a break
        drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        wait_clks(20 * BIT);
        check("t3_ferr", 32'(frame_err), 1);
        check("t3_data", 32'(rx_data), 32'h3C);
        rx = 1'b1;
        wait_clks(BIT);
        drive_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, -1, 20);
        check("t3_after_data", 32'(rx_data), 32'hA5);
        check("t3_after_ferr", 32'(frame_err), 0);

        // glitch shorter than mid-bit
        rx = 1'b0;
        wait_clks(10);
        check("t4_glitch_busy", 32'(rx_busy), 1);
        wait_clks(3 * DIV - 10);
        rx = 1'b1;
        for (int k = 0; k < BIT; k++) begin
            if (!rx_busy) break;
            wait_clks(1);
        end
        check("t4_glitch_idle", 32'(rx_busy), 0);
        wait_clks(BIT);
        drive_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 3, 20);
        check("t4_vote_lo", 32'(rx_data), 32'h81);
        drive_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 7, 20);
        check("t4_vote_hi", 32'(rx_data), 32'h81);

        // back-to-back
        drive_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0);
        drive_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, -1, 20);
        check("t5_data", 32'(rx_data), 32'hFF);

        // reset during data bit 4
        d = 8'h33;
        parity_enable = 1'b0;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clks(BIT);
        end
        rx = d[4];
        wait_clks(BIT / 2);
        resetn = 1'b0;
        #1;
        check("t6_rst_data", 32'(rx_data), 0);
        check("t6_rst_busy", 32'(rx_busy), 0);
        check("t6_rst_ready", 32'(data_ready), 0);
        rx = 1'b1;
        wait_clks(3);
        resetn = 1'b1;
        wait_clks(BIT);
        drive_frame(8'h6E, 1'b0, 1'b0, 1'b1, 1'b0, -1, 20);
        check("t6_data", 32'(rx_data), 32'h6E);

        // random frames
        for (int n = 0; n < 40; n++) begin
            d    = DB'($urandom);
            pen  = 1'($urandom);
            pbit = ($urandom_range(0, 2) == 0) ? ~(^d) : (^d);
            stop = ($urandom_range(0, 9) != 0);
            cor  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DB - 1)) : -1;
            gap  = stop ? int'($urandom_range(0, 150)) : int'($urandom_range(3, 150));
            drive_frame(d, pen, pbit, stop, 1'($urandom), cor, gap);
        end

        rx = 1'b1;
        wait_clks(3 * BIT);
        check("queue_drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Oversampling UART receiver that converts the serial line back into parallel words. It is the receive end of the team's UART path and is what the loopback wrapper's rx_data, data_ready, parity_err and frame_err outputs are driven from. Frame format: 1 start bit, DATA_BITS data bits (LSB first), optional even parity bit, 1 stop bit. Each bit is decided by a 3-sample majority vote at mid-bit.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
BAUD_RATE, 115200, line rate in bit/s
CLK_FREQ, 100000000, clk frequency in Hz
OVS_FACTOR, 16, oversample ticks per bit; even, >= 8

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
parity_enable  input  1  1 = frame carries an even parity bit; latched at start detect
rx_data  output  DATA_BITS  last received word
data_ready  output  1  one-cycle pulse: rx_data, parity_err and frame_err updated
parity_err  output  1  parity mismatch on last frame (0 when parity disabled)
frame_err  output  1  stop bit sampled 0 on last frame
rx_busy  output  1  high from start detect until return to IDLE

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on resetn.
- Reset values: rx_data=0, data_ready=0, parity_err=0, frame_err=0, rx_busy=0. Synchronizer flops reset to 1. State is IDLE.
- Reset mid-frame: the frame is abandoned with no data_ready.
- Input synchronizer: rx passes through a 2-flop synchronizer. All logic uses the synced value (rx_s).
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVS_FACTOR), integer truncation (54 for defaults).
  - tick pulses for 1 cycle when the divider counter reaches DIV-1; the counter then wraps to 0.
  - The divider counter and the OVS counter (0..OVS_FACTOR-1) both clear on start detect.
  - Elaboration must fail if DIV < 2.
- Sampling:
  - Within each bit, samples are taken on the ticks where the OVS counter equals OVS_FACTOR/2-1, OVS_FACTOR/2 and OVS_FACTOR/2+1.
  - The bit value is the majority of the 3 samples, decided on the third sample tick.
- State machine:
  - IDLE: rx_busy=0. An rx_s=0 while armed moves to START, latches parity_enable and sets rx_busy=1.
  - START: majority=1 means a false start; go to IDLE with no data_ready. Majority=0 goes to DATA at the end of the bit (OVS counter wraps).
  - DATA: shift the majority value into a shift register LSB first. After DATA_BITS bits go to PARITY if the latched parity_enable=1, else to STOP.
  - PARITY: the computed error is parity_err_next = XOR(data bits, parity bit). Even parity: the total count of ones must be even.
  - STOP: on the majority decision, go to IDLE immediately, half a bit early, so back-to-back frames are caught.
- Frame completion:
  - The cycle after the STOP decision, data_ready=1 for exactly 1 cycle.
  - rx_data, parity_err and frame_err load on that same cycle and hold until the next data_ready.
  - rx_data is updated even when parity_err or frame_err is set.
- Re-arming: after any return to IDLE, start detect is armed only once rx_s has been 1 for at least one cycle. A break or a stuck-low line therefore produces exactly one frame_err and no retriggering.
- Latency: data_ready rises about (1+DATA_BITS+P)*OVS_FACTOR*DIV + (OVS_FACTOR/2+2)*DIV + 3 clk after the falling start edge, where P = parity bit present.
- Simultaneous events: a new falling edge arriving while the FSM is not in IDLE is ignored, because detection happens only in IDLE.
- Widths: the divider counter is $clog2(DIV) bits and the OVS counter is $clog2(OVS_FACTOR) bits. Both wrap without overflow.

Test Plan:
1. Defaults, parity_enable=0. Send 0xD5 with bit time 864 clk and stop=1. Required: one data_ready pulse, rx_data=0xD5, parity_err=0, frame_err=0, rx_busy=0 afterward.
2. parity_enable=1. Send 0xD5 with parity bit 1: no error. Resend 0xD5 with parity bit 0: parity_err=1 and rx_data=0xD5. Toggling parity_enable mid-frame has no effect.
3. Drive stop bit 0 for 0x3C, then hold rx low for 2 frame times. Required: exactly one data_ready with frame_err=1 and rx_data=0x3C. Then release rx high and send 0xA5: rx_data=0xA5, frame_err=0.
4. Glitch: rx low for 3 ticks (162 clk), then high. Required: no data_ready, and rx_busy returns to 0 within 1 bit time. Separately, corrupt exactly one of the 3 mid-bit samples in a data bit of 0x81: rx_data=0x81.
5. Back-to-back frames 0x00 then 0xFF with zero idle between stop and start. Required: two data_ready pulses, values in that order, no errors.
6. Assert resetn=0 during data bit 4 of a frame. Required: all outputs 0 immediately and no data_ready. After release, a new 0x6E frame is received correctly.
